// File: rtl/multi_master_tristate_bus_if.sv
// Shared-bus interface: master-side write ports plus the registered
// arbitration and capture outputs common to every master.
interface multi_master_tristate_bus_if #(
  parameter int N = 8,
  parameter int M = 4
);
  localparam int OW = (M > 1) ? $clog2(M) : 1;

  logic [M*N-1:0] data_in;
  logic [M-1:0]   req;
  logic [M-1:0]   gnt;
  logic [OW-1:0]  owner;
  logic           bus_busy;
  logic [N-1:0]   data_out;
  logic           data_valid;

  modport master (
    output data_in, req,
    input  gnt, owner, bus_busy, data_out, data_valid
  );

  modport slave (
    input  data_in, req,
    output gnt, owner, bus_busy, data_out, data_valid
  );
endinterface

// File: rtl/multi_master_tristate_bus.sv
// M masters sharing one N-bit tri-state bus. A registered round-robin
// arbiter grants one master at a time, limits a contended burst to
// HOLD_MAX cycles and inserts one idle turnaround cycle between owners
// so two drivers never overlap. The bus is captured into data_out with
// a valid strobe one cycle after each driven cycle.
module multi_master_tristate_bus #(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int HOLD_MAX = 4
) (
  input logic clk,
  input logic rst,
  multi_master_tristate_bus_if.slave bus
);
  localparam int OW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
  localparam logic [OW-1:0] LAST_ID  = OW'(M - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t        state;
  logic [M-1:0]  gnt_r;
  logic [OW-1:0] owner_r;
  logic [OW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic          busy_r;
  logic [N-1:0]  dout_r;
  logic          valid_r;

  tri   [N-1:0]  bi_data;

  logic [OW-1:0] win;
  logic          found;
  int            idx;
  logic          other_req;
  logic [OW-1:0] next_ptr;

  // One tri-state driver per master, enabled only by its own grant bit
  for (genvar k = 0; k < M; k++) begin : g_drv
    assign bi_data = gnt_r[k] ? bus.data_in[k*N +: N] : {N{1'bz}};
  end

  // Round-robin search: first requester at or after the pointer, wrapping
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < M; i++) begin
      idx = int'(ptr) + i;
      if (idx >= M) idx = idx - M;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  // Contention seen by the current owner and the pointer after its release
  always_comb begin
    other_req = |(bus.req & ~gnt_r);
    next_ptr  = (owner_r == LAST_ID) ? '0 : owner_r + 1'b1;
  end

  // Arbiter state machine with registered grant, owner and capture outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      gnt_r   <= '0;
      owner_r <= '0;
      ptr     <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      dout_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        GRANT: begin
          dout_r  <= bi_data;
          valid_r <= 1'b1;
          if (!bus.req[owner_r] || (cnt == HOLD_LIM && other_req)) begin
            state  <= TURN;
            gnt_r  <= '0;
            busy_r <= 1'b0;
            ptr    <= next_ptr;
          end else if (cnt != HOLD_LIM) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          valid_r <= 1'b0;
          if (found) begin
            state   <= GRANT;
            gnt_r   <= M'(1) << win;
            owner_r <= win;
            cnt     <= CW'(1);
            busy_r  <= 1'b1;
          end else begin
            state  <= IDLE;
            gnt_r  <= '0;
            busy_r <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.owner      = owner_r;
  assign bus.bus_busy   = busy_r;
  assign bus.data_out   = dout_r;
  assign bus.data_valid = valid_r;
endmodule

// File: tb/tb_multi_master_tristate_bus.sv
// Testbench for multi_master_tristate_bus: directed scenarios followed by
// random traffic, checked against a behavioural arbitration model through
// a per-cycle control queue and a separate captured-data queue.
module tb_multi_master_tristate_bus;
  localparam int N        = 8;
  localparam int M        = 4;
  localparam int HOLD_MAX = 4;
  localparam int OW       = (M > 1) ? $clog2(M) : 1;

  typedef struct {
    logic [M-1:0]  gnt;
    logic [OW-1:0] owner;
    logic          busy;
    logic          valid;
    logic [N-1:0]  dout;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  exp_t         ctrl_q[$];
  logic [N-1:0] data_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state: who holds the bus, for how long, where search starts
  int           m_cur   = -1;
  int           m_held  = 0;
  int           m_ptr   = 0;
  int           m_owner = 0;
  logic [N-1:0] m_dout  = '0;

  multi_master_tristate_bus_if #(.N(N), .M(M)) bus_if ();

  multi_master_tristate_bus #(.N(N), .M(M), .HOLD_MAX(HOLD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic int pick(input logic [M-1:0] r, input int p);
    for (int i = 0; i < M; i++) begin
      if (r[(p + i) % M]) return (p + i) % M;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [M-1:0] q, input logic [M*N-1:0] d, input int n);
    rst            = r;
    bus_if.req     = q;
    bus_if.data_in = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: predict post-edge outputs from the inputs seen at each rising edge
  always @(posedge clk) begin
    exp_t e;
    logic valid;
    int   w;
    valid = 1'b0;
    if (!rst) begin
      m_cur = -1; m_held = 0; m_ptr = 0; m_owner = 0; m_dout = '0;
    end else if (m_cur >= 0) begin
      m_dout = bus_if.data_in[m_cur*N +: N];
      valid  = 1'b1;
      data_q.push_back(m_dout);
      if (!bus_if.req[m_cur] || (m_held >= HOLD_MAX && (bus_if.req & ~(M'(1) << m_cur)) != '0)) begin
        m_ptr = (m_cur + 1) % M;
        m_cur = -1;
      end else if (m_held < HOLD_MAX) begin
        m_held++;
      end
    end else begin
      w = pick(bus_if.req, m_ptr);
      if (w >= 0) begin
        m_cur = w; m_held = 1; m_owner = w;
      end
    end
    e.gnt   = (m_cur >= 0) ? M'(1) << m_cur : '0;
    e.owner = OW'(m_owner);
    e.busy  = (m_cur >= 0);
    e.valid = valid;
    e.dout  = m_dout;
    ctrl_q.push_back(e);
  end

  // Monitor: compare control every cycle, pop captured data whenever valid
  always @(negedge clk) begin
    exp_t e;
    logic [N-1:0] d;
    checks++;
    if ($countones(bus_if.gnt) > 1) begin
      errors++;
      $display("[TB] FAIL gnt_onehot at %0t: got %b expected at most one bit", $time, bus_if.gnt);
    end
    if (ctrl_q.size() > 0) begin
      e = ctrl_q.pop_front();
      checkOutput("gnt",        32'(bus_if.gnt),        32'(e.gnt));
      checkOutput("owner",      32'(bus_if.owner),      32'(e.owner));
      checkOutput("bus_busy",   32'(bus_if.bus_busy),   32'(e.busy));
      checkOutput("data_valid", 32'(bus_if.data_valid), 32'(e.valid));
      checkOutput("data_out",   32'(bus_if.data_out),   32'(e.dout));
    end
    if (bus_if.data_valid === 1'b1) begin
      if (data_q.size() == 0) begin
        checkOutput("data_unexpected", 32'(bus_if.data_out), 32'hFFFF_FFFF);
      end else begin
        d = data_q.pop_front();
        checkOutput("data_scoreboard", 32'(bus_if.data_out), 32'(d));
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, random traffic, drain and summary
  initial begin
    int w;
    applyStimulus(1'b0, 4'b1111, 32'hFFFF_FFFF, 2);
    applyStimulus(1'b1, 4'b0001, 32'h0000_00AA, 3);
    applyStimulus(1'b1, 4'b0000, 32'h0000_00AA, 3);
    applyStimulus(1'b1, 4'b1111, 32'h4433_2211, 20);
    applyStimulus(1'b1, 4'b0100, 32'h005A_0000, 10);
    applyStimulus(1'b1, 4'b0000, 32'h005A_0000, 2);
    applyStimulus(1'b1, 4'b1111, 32'h4433_2211, 7);
    applyStimulus(1'b0, 4'b1111, 32'h4433_2211, 1);
    applyStimulus(1'b1, 4'b1111, 32'h4433_2211, 3);
    applyStimulus(1'b1, 4'b0000, 32'h4433_2211, 3);
    applyStimulus(1'b1, 4'b0001, 32'h7700_0066, 3);
    applyStimulus(1'b1, 4'b1000, 32'h7700_0066, 4);
    for (int i = 0; i < 400; i++) begin
      logic [M-1:0] r;
      r = M'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      applyStimulus(($urandom_range(0, 63) != 0), r, $urandom, $urandom_range(1, 6));
    end
    applyStimulus(1'b1, 4'b0000, 32'h0, 4);
    w = 0;
    while ((ctrl_q.size() != 0 || data_q.size() != 0) && w < 10) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_data_q", 32'(data_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_master_tristate_bus.md
Name: multi_master_tristate_bus

Overview:
- Parametrised successor to the two-device tri-state bus: M masters share one N-bit tri-state bus, with a registered round-robin arbiter.
- Adds a bounded burst (HOLD_MAX cycles) and a mandatory one-cycle turnaround between owners so no two drivers overlap.
- All masters observe a common registered bus capture with a valid strobe and owner ID.
- Sits between peripheral write ports and the shared on-chip data path.

Parameters:
- N, 8, bus data width in bits
- M, 4, number of masters (2..16)
- HOLD_MAX, 4, maximum consecutive grant cycles while another master is requesting (>=1)
- OW, max(1,$clog2(M)), localparam: owner-ID width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (rst==0 sampled at posedge resets all state)
- data_in  input  M*N  master k drives slice [k*N +: N]
- req  input  M  request per master, level-sensitive
- gnt  output  M  one-hot registered grant; master k drives bus only while gnt[k]==1
- owner  output  OW  index of current/last granted master
- bus_busy  output  1  1 while in GRANT state
- data_out  output  N  registered capture of the internal bus, common to all masters
- data_valid  output  1  1 for the cycle after each cycle in which the bus was driven

Behaviour:
- Internal bus bi_data (N-bit wire): M tri-state drivers, bi_data = gnt[k] ? data_in slice k : 'z. All drivers released when gnt==0.
- Reset (rst==0 at edge): state=IDLE, gnt=0, owner=0, rr pointer=0, hold count=0, bus_busy=0, data_out=0, data_valid=0. Reset overrides all other events, including mid-grant; bus floats from the following cycle.
- Arbitration function: search req starting at pointer, ascending modulo M; the first set bit wins.
- States:
  - IDLE: gnt=0. If any req at the edge -> GRANT with winner, gnt=onehot(winner), owner=winner, cnt=1.
  - GRANT: owner drives bus. Each edge: data_out<=bi_data, data_valid<=1.
    - req[owner]==0 -> TURN, pointer=owner+1 mod M.
    - Else if cnt==HOLD_MAX and some other req set -> TURN, pointer=owner+1 mod M.
    - Else stay. cnt increments, saturating at HOLD_MAX; a lone requester keeps the bus indefinitely with no turnaround.
  - TURN: exactly one cycle, gnt=0, bus Z. Next edge arbitrates as in IDLE: -> GRANT if any req, else IDLE.
- Latency:
  - req high in cycle t, state IDLE -> gnt high in cycle t+1.
  - First data_out/data_valid in cycle t+2.
- data_valid: 0 in any cycle following an IDLE/TURN cycle. data_out holds its last value while not valid.
- gnt is always zero or one-hot; never two drivers in any cycle, including across an owner change.
- Dropping req: the owner's req deasserted in cycle c means that cycle's data is still captured; gnt falls at the edge ending c.
- Simultaneous events: a master raising req in the same cycle the owner drops competes at TURN->GRANT using the updated pointer.
- Overflow/width: cnt width = $clog2(HOLD_MAX+1); pointer wraps M-1 -> 0.

Test Plan (M=4, N=8, HOLD_MAX=4):
1. Reset: rst=0 for 2 edges with req=4'b1111, data_in all 8'hFF -> gnt=0, owner=0, data_out=8'h00, data_valid=0, bus=zz; release rst -> gnt=4'b0001 one edge later.
2. Single master: req=4'b0001, din0=8'hAA held 3 cycles.
   - Expect gnt=0001 for 3 cycles, then data_out=AA/data_valid=1 one cycle later.
   - After req drops: one TURN cycle (gnt=0, bus zz), then IDLE; data_out stays AA with valid=0.
3. Round-robin with hold limit: req=4'b1111, din0..3=11,22,33,44.
   - Grants 0001 x4, 0000, 0010 x4, 0000, 0100 x4, 0000, 1000 x4, 0000, then 0001.
   - data_out sequence 11,11,11,11,22,... with valid low after each TURN.
4. Lone requester: req=4'b0100, din2=8'h5A for 10 cycles -> gnt=0100 continuously, no TURN, data_valid=1 for 10 cycles, owner=2.
5. Reset mid-grant: during item 3 with gnt=0010, assert rst=0 for one edge.
   - gnt=0, data_out=00 at that edge.
   - After release, req=1111 -> gnt=0001 (pointer back to 0).
6. Contention check: assertion over all tests that $countones(gnt)<=1 and bi_data has no X bits while any gnt set; simultaneous owner drop plus new req from master 3 -> master 3 granted after exactly one TURN cycle.
